// File: rtl/serial_pattern_tx.sv
// Serialises a parallel pattern MSB-first onto x, one bit per clock, with an
// optional low idle gap after each frame. Feeds the x input of sequence detectors.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy,
    output logic             done
);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE_ZERO} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] aligned;
    logic             take;

    // Clamp the length, then left-justify so bit [len-1] lands in the MSB.
    assign len_eff = (pat_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : pat_len;
    assign aligned = pat_in << (LEN_W'(WIDTH) - len_eff);

    assign last      = reset && (state == S_SHIFT) && x_valid && (bit_cnt == LEN_W'(1));
    assign pat_ready = reset && ((state == S_IDLE) || ((GAP == 0) && last));
    assign take      = pat_valid && pat_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: ;
                S_SHIFT: begin
                    if (bit_cnt == LEN_W'(1)) begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        if (GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= GW'(GAP);
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        shreg   <= shreg << 1;
                        x       <= shreg[WIDTH-2];
                        bit_cnt <= bit_cnt - LEN_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                S_DONE_ZERO: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase

            // A load overrides the end-of-frame path but keeps its done pulse.
            if (take) begin
                shreg   <= aligned;
                bit_cnt <= len_eff;
                if (len_eff != '0) begin
                    state   <= S_SHIFT;
                    x       <= aligned[WIDTH-1];
                    x_valid <= 1'b1;
                    busy    <= 1'b1;
                end else begin
                    state   <= S_DONE_ZERO;
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            end
        end
    end
endmodule
